// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and the ID/EX control bundle for the MIPS pipeline control unit.
// Everything the decoder and the top level agree on lives here.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_DIVU   = 6'h1b;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h2b;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BNE  = 3'b001;
  localparam logic [2:0] BT_BLEZ = 3'b010;
  localparam logic [2:0] BT_BGTZ = 3'b011;
  localparam logic [2:0] BT_NONE = 3'b100;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_AND = 3'b100;
  localparam logic [2:0] ALUOP_SLT = 3'b101;
  localparam logic [2:0] ALUOP_MUL = 3'b110;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic [1:0] pcsrc;
    logic       branch;
    logic [2:0] branch_type;
    logic       regwrite;
    logic [1:0] regdst;
    logic       memread;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luop;
    logic [3:0] aluop;
  } ctrl_bundle_t;

  // Field order follows ctrl_bundle_t; only branch_type is non-zero.
  localparam ctrl_bundle_t BUBBLE = '{1'b0, 1'b0, PCSRC_SEQ, 1'b0, BT_NONE, 1'b0,
                                      2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
                                      1'b0, 1'b0, 4'h0};

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational OpCode/Funct decoder producing the raw control bundle plus
// illegal / mult-div / HI-LO-reader classification flags.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o,
  output logic         is_md_o,
  output logic         is_hilo_rd_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // statements can leave a value unassigned and infer a latch.
    ctrl_o             = BUBBLE;
    ctrl_o.valid       = 1'b1;
    ctrl_o.extop       = 1'b1;
    ctrl_o.alusrc2     = 1'b1;
    ctrl_o.aluop       = {opcode_i[0], ALUOP_ADD};
    illegal_o          = 1'b0;
    is_md_o            = 1'b0;
    is_hilo_rd_o       = 1'b0;

    case (opcode_i) inside
      OP_RTYPE: begin
        ctrl_o.aluop[2:0] = ALUOP_R;
        ctrl_o.alusrc2    = 1'b0;
        ctrl_o.regdst     = REGDST_RD;
        case (funct_i) inside
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc1  = 1'b1;
          end
          FN_JR:   ctrl_o.pcsrc = PCSRC_JR;
          FN_JALR: begin
            ctrl_o.pcsrc    = PCSRC_JR;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.memtoreg = MEMTOREG_PC;
          end
          FN_MFHI, FN_MFLO: begin
            ctrl_o.regwrite = 1'b1;
            is_hilo_rd_o    = 1'b1;
          end
          [FN_MULT:FN_DIVU]:     is_md_o         = 1'b1;
          [FN_ALU_LO:FN_ALU_HI]: ctrl_o.regwrite = 1'b1;
          default:               illegal_o       = 1'b1;
        endcase
      end
      OP_J: ctrl_o.pcsrc = PCSRC_J;
      OP_JAL: begin
        ctrl_o.pcsrc    = PCSRC_J;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = REGDST_RA;
        ctrl_o.memtoreg = MEMTOREG_PC;
      end
      [OP_BEQ:OP_BGTZ]: begin
        // Branch opcodes are consecutive, so the low bits select the compare.
        ctrl_o.branch      = 1'b1;
        ctrl_o.pcsrc       = PCSRC_BR;
        ctrl_o.alusrc2     = 1'b0;
        ctrl_o.branch_type = {1'b0, opcode_i[1:0]};
        ctrl_o.aluop[2:0]  = opcode_i[1] ? ALUOP_ADD : ALUOP_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = REGDST_RT;
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = REGDST_RT;
        ctrl_o.aluop[2:0] = ALUOP_SLT;
        ctrl_o.alusrc2    = (opcode_i != OP_SLTIU);
      end
      OP_ANDI: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = REGDST_RT;
        ctrl_o.extop      = 1'b0;
        ctrl_o.aluop[2:0] = ALUOP_AND;
      end
      OP_LUI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = REGDST_RT;
        ctrl_o.luop     = 1'b1;
      end
      OP_MUL: begin
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.regdst     = REGDST_RD;
        ctrl_o.alusrc2    = 1'b0;
        ctrl_o.aluop[2:0] = ALUOP_MUL;
      end
      OP_LW: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = REGDST_RT;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = MEMTOREG_MEM;
      end
      OP_SW:   ctrl_o.memwrite = 1'b1;
      default: illegal_o       = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall-aware ID/EX control register: decodes the ID instruction, launches it or a
// bubble, and interlocks HI/LO consumers while a mult/div is in flight.
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter bit EN_TRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       stall_in,
  input  logic       flush,
  output logic       id_stall,
  output logic       md_busy,
  output logic       ex_valid,
  output logic [1:0] ex_pcsrc,
  output logic       ex_branch,
  output logic       ex_regwrite,
  output logic       ex_memread,
  output logic       ex_memwrite,
  output logic       ex_alusrc1,
  output logic       ex_alusrc2,
  output logic       ex_extop,
  output logic       ex_luop,
  output logic       ex_illegal,
  output logic [1:0] ex_regdst,
  output logic [1:0] ex_memtoreg,
  output logic [3:0] ex_aluop,
  output logic [2:0] ex_branch_type
);

  localparam int            CW       = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

  ctrl_bundle_t  dec_raw, dec_bundle, bundle_d, bundle_q;
  logic          dec_illegal, dec_is_md, dec_is_hilo_rd;
  logic          interlock, launch, md_start;
  md_state_e     state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;

  mips_ctrl_decode u_decode (
    .opcode_i     (OpCode),
    .funct_i      (Funct),
    .ctrl_o       (dec_raw),
    .illegal_o    (dec_illegal),
    .is_md_o      (dec_is_md),
    .is_hilo_rd_o (dec_is_hilo_rd)
  );

  // The last BUSY cycle (cnt==0) is not interlocked: HI/LO is ready at that edge.
  assign interlock = !reset && (state_q == MD_BUSY) && (cnt_q != '0) && in_valid
                     && (dec_is_md || dec_is_hilo_rd);
  assign id_stall  = stall_in || interlock;
  assign launch    = in_valid && !flush && !id_stall;
  assign md_start  = launch && dec_is_md;
  assign md_busy   = (state_q == MD_BUSY);

  always_comb begin
    dec_bundle = dec_raw;
    if (dec_illegal) begin
      if (EN_TRAP) begin
        dec_bundle.illegal  = 1'b1;
        dec_bundle.regwrite = 1'b0;
        dec_bundle.memread  = 1'b0;
        dec_bundle.memwrite = 1'b0;
        dec_bundle.branch   = 1'b0;
        dec_bundle.pcsrc    = PCSRC_SEQ;
      end else begin
        dec_bundle       = BUBBLE;
        dec_bundle.valid = 1'b1;
      end
    end
    bundle_d = launch ? dec_bundle : BUBBLE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (md_start) begin
          // A mult/div launching on the final edge re-arms without an idle gap.
          cnt_d = CNT_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      bundle_q <= BUBBLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
    end
  end

  assign ex_valid       = bundle_q.valid;
  assign ex_illegal     = bundle_q.illegal;
  assign ex_pcsrc       = bundle_q.pcsrc;
  assign ex_branch      = bundle_q.branch;
  assign ex_branch_type = bundle_q.branch_type;
  assign ex_regwrite    = bundle_q.regwrite;
  assign ex_regdst      = bundle_q.regdst;
  assign ex_memread     = bundle_q.memread;
  assign ex_memwrite    = bundle_q.memwrite;
  assign ex_memtoreg    = bundle_q.memtoreg;
  assign ex_alusrc1     = bundle_q.alusrc1;
  assign ex_alusrc2     = bundle_q.alusrc2;
  assign ex_extop       = bundle_q.extop;
  assign ex_luop        = bundle_q.luop;
  assign ex_aluop       = bundle_q.aluop;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed scoreboard bench for pipe_ctrl_unit: each step queues the bundle the DUT
// should launch at the coming edge and checks the previous one on the next negedge.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset, in_valid, stall_in, flush;
  logic [5:0] OpCode, Funct;

  logic       id_stall, md_busy, ex_valid, ex_branch, ex_regwrite, ex_memread, ex_memwrite;
  logic       ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_illegal;
  logic [1:0] ex_pcsrc, ex_regdst, ex_memtoreg;
  logic [3:0] ex_aluop;
  logic [2:0] ex_branch_type;

  logic       nt_id_stall, nt_md_busy, nt_valid, nt_branch, nt_regwrite, nt_memread, nt_memwrite;
  logic       nt_alusrc1, nt_alusrc2, nt_extop, nt_luop, nt_illegal;
  logic [1:0] nt_pcsrc, nt_regdst, nt_memtoreg;
  logic [3:0] nt_aluop;
  logic [2:0] nt_branch_type;

  pipe_ctrl_unit #(.MD_LATENCY(4), .EN_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .OpCode(OpCode), .Funct(Funct),
    .stall_in(stall_in), .flush(flush), .id_stall(id_stall), .md_busy(md_busy),
    .ex_valid(ex_valid), .ex_pcsrc(ex_pcsrc), .ex_branch(ex_branch),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_extop(ex_extop),
    .ex_luop(ex_luop), .ex_illegal(ex_illegal), .ex_regdst(ex_regdst),
    .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop), .ex_branch_type(ex_branch_type)
  );

  pipe_ctrl_unit #(.MD_LATENCY(4), .EN_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .in_valid(in_valid), .OpCode(OpCode), .Funct(Funct),
    .stall_in(stall_in), .flush(flush), .id_stall(nt_id_stall), .md_busy(nt_md_busy),
    .ex_valid(nt_valid), .ex_pcsrc(nt_pcsrc), .ex_branch(nt_branch),
    .ex_regwrite(nt_regwrite), .ex_memread(nt_memread), .ex_memwrite(nt_memwrite),
    .ex_alusrc1(nt_alusrc1), .ex_alusrc2(nt_alusrc2), .ex_extop(nt_extop),
    .ex_luop(nt_luop), .ex_illegal(nt_illegal), .ex_regdst(nt_regdst),
    .ex_memtoreg(nt_memtoreg), .ex_aluop(nt_aluop), .ex_branch_type(nt_branch_type)
  );

  always #5 clk = ~clk;

  logic [22:0] obs_vec, nt_vec;
  assign obs_vec = {ex_valid, ex_illegal, ex_pcsrc, ex_branch, ex_branch_type, ex_regwrite,
                    ex_regdst, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc1, ex_alusrc2,
                    ex_extop, ex_luop, ex_aluop};
  assign nt_vec  = {nt_valid, nt_illegal, nt_pcsrc, nt_branch, nt_branch_type, nt_regwrite,
                    nt_regdst, nt_memread, nt_memwrite, nt_memtoreg, nt_alusrc1, nt_alusrc2,
                    nt_extop, nt_luop, nt_aluop};

  function automatic logic [22:0] bund(
      input logic v, il, input logic [1:0] pc, input logic br, input logic [2:0] bt,
      input logic rw, input logic [1:0] rd, input logic mr, mw, input logic [1:0] mt,
      input logic a1, a2, ex, lu, input logic [3:0] op);
    return {v, il, pc, br, bt, rw, rd, mr, mw, mt, a1, a2, ex, lu, op};
  endfunction

  localparam logic [22:0] M_ALL  = '1;
  // valid, illegal, pcsrc, branch, regwrite, memread, memwrite
  localparam logic [22:0] M_ILL  = bund(1,1,2'b11,1,3'b000,1,2'b00,1,1,2'b00,0,0,0,0,4'h0);
  // illegal, pcsrc, branch, regwrite, memread, memwrite
  localparam logic [22:0] M_NT   = bund(0,1,2'b11,1,3'b000,1,2'b00,1,1,2'b00,0,0,0,0,4'h0);
  localparam logic [22:0] E_BUB  = bund(0,0,2'b00,0,3'b100,0,2'b00,0,0,2'b00,0,0,0,0,4'b0000);
  localparam logic [22:0] E_LW   = bund(1,0,2'b00,0,3'b100,1,2'b01,1,0,2'b01,0,1,1,0,4'b1000);
  localparam logic [22:0] E_BEQ  = bund(1,0,2'b01,1,3'b000,0,2'b00,0,0,2'b00,0,0,1,0,4'b0001);
  localparam logic [22:0] E_BNE  = bund(1,0,2'b01,1,3'b001,0,2'b00,0,0,2'b00,0,0,1,0,4'b1001);
  localparam logic [22:0] E_MULT = bund(1,0,2'b00,0,3'b100,0,2'b00,0,0,2'b00,0,0,1,0,4'b0010);
  localparam logic [22:0] E_MFX  = bund(1,0,2'b00,0,3'b100,1,2'b00,0,0,2'b00,0,0,1,0,4'b0010);
  localparam logic [22:0] E_ILL  = bund(1,1,2'b00,0,3'b100,0,2'b00,0,0,2'b00,0,0,0,0,4'b0000);
  localparam logic [22:0] E_ADDI = bund(1,0,2'b00,0,3'b100,1,2'b01,0,0,2'b00,0,1,1,0,4'b0000);
  localparam logic [22:0] E_ANDI = bund(1,0,2'b00,0,3'b100,1,2'b01,0,0,2'b00,0,1,0,0,4'b0100);
  localparam logic [22:0] E_LUI  = bund(1,0,2'b00,0,3'b100,1,2'b01,0,0,2'b00,0,1,1,1,4'b1000);
  localparam logic [22:0] E_JAL  = bund(1,0,2'b10,0,3'b100,1,2'b10,0,0,2'b10,0,1,1,0,4'b1000);
  localparam logic [22:0] E_JR   = bund(1,0,2'b11,0,3'b100,0,2'b00,0,0,2'b00,0,0,1,0,4'b0010);
  localparam logic [22:0] E_SLL  = bund(1,0,2'b00,0,3'b100,1,2'b00,0,0,2'b00,1,0,1,0,4'b0010);
  localparam logic [22:0] E_SLTU = bund(1,0,2'b00,0,3'b100,1,2'b01,0,0,2'b00,0,0,1,0,4'b1101);

  typedef struct {
    string       tag;
    logic [22:0] exp;
    logic [22:0] mask;
    logic        chk_nt;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_compare();
    sb_t e;
    e = sb_q.pop_front();
    check({e.tag, "/bundle"}, 32'(obs_vec & e.mask), 32'(e.exp & e.mask));
    if (e.chk_nt) check({e.tag, "/notrap"}, 32'(nt_vec & M_NT), 32'd0);
  endtask

  task automatic step(input string tag, input logic rst, vld, input logic [5:0] op, fn,
                      input logic stl, fl, input logic [22:0] exp_b, msk, input logic nt,
                      input logic exp_stall, exp_busy);
    @(negedge clk);
    if (sb_q.size() > 0) pop_compare();
    check({tag, "/md_busy"}, 32'(md_busy), 32'(exp_busy));
    check({tag, "/nt_md_busy"}, 32'(nt_md_busy), 32'(exp_busy));
    reset    = rst;
    in_valid = vld;
    OpCode   = op;
    Funct    = fn;
    stall_in = stl;
    flush    = fl;
    #1;
    check({tag, "/id_stall"}, 32'(id_stall), 32'(exp_stall));
    check({tag, "/nt_id_stall"}, 32'(nt_id_stall), 32'(exp_stall));
    sb_q.push_back('{tag, exp_b, msk, nt});
  endtask

  task automatic go(input string tag, input logic vld, input logic [5:0] op, fn,
                    input logic [22:0] exp_b, input logic exp_stall, exp_busy);
    step(tag, 1'b0, vld, op, fn, 1'b0, 1'b0, exp_b, M_ALL, 1'b0, exp_stall, exp_busy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; OpCode = 6'h00; Funct = 6'h00;
    stall_in = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);

    step("reset", 1'b1, 1'b1, 6'h23, 6'h00, 1'b1, 1'b0, E_BUB, M_ALL, 1'b0, 1'b1, 1'b0);
    go("lw",      1'b1, 6'h23, 6'h00, E_LW,   1'b0, 1'b0);
    go("beq",     1'b1, 6'h04, 6'h00, E_BEQ,  1'b0, 1'b0);
    go("bne",     1'b1, 6'h05, 6'h00, E_BNE,  1'b0, 1'b0);
    go("novalid", 1'b0, 6'h23, 6'h00, E_BUB,  1'b0, 1'b0);

    // mult then mflo: 4 busy cycles, 3 interlocked, mflo launches on the 4th edge
    go("mult",    1'b1, 6'h00, 6'h18, E_MULT, 1'b0, 1'b0);
    go("mflo_s1", 1'b1, 6'h00, 6'h12, E_BUB,  1'b1, 1'b1);
    go("mflo_s2", 1'b1, 6'h00, 6'h12, E_BUB,  1'b1, 1'b1);
    go("mflo_s3", 1'b1, 6'h00, 6'h12, E_BUB,  1'b1, 1'b1);
    go("mflo_go", 1'b1, 6'h00, 6'h12, E_MFX,  1'b0, 1'b1);
    go("md_idle", 1'b0, 6'h00, 6'h00, E_BUB,  1'b0, 1'b0);

    step("flush_stall_sw", 1'b0, 1'b1, 6'h2b, 6'h00, 1'b1, 1'b1, E_BUB, M_ALL, 1'b0, 1'b1, 1'b0);
    step("flush_mult", 1'b0, 1'b1, 6'h00, 6'h19, 1'b0, 1'b1, E_BUB, M_ALL, 1'b0, 1'b0, 1'b0);
    go("after_flush", 1'b0, 6'h00, 6'h00, E_BUB, 1'b0, 1'b0);
    step("stall_div", 1'b0, 1'b1, 6'h00, 6'h1a, 1'b1, 1'b0, E_BUB, M_ALL, 1'b0, 1'b1, 1'b0);
    go("after_stall", 1'b0, 6'h00, 6'h00, E_BUB, 1'b0, 1'b0);

    step("illegal", 1'b0, 1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, E_ILL, M_ILL, 1'b1, 1'b0, 1'b0);
    go("addi",  1'b1, 6'h08, 6'h00, E_ADDI, 1'b0, 1'b0);
    go("andi",  1'b1, 6'h0c, 6'h00, E_ANDI, 1'b0, 1'b0);
    go("lui",   1'b1, 6'h0f, 6'h00, E_LUI,  1'b0, 1'b0);
    go("jal",   1'b1, 6'h03, 6'h00, E_JAL,  1'b0, 1'b0);
    go("jr",    1'b1, 6'h00, 6'h08, E_JR,   1'b0, 1'b0);
    go("sll",   1'b1, 6'h00, 6'h00, E_SLL,  1'b0, 1'b0);
    go("sltiu", 1'b1, 6'h0b, 6'h00, E_SLTU, 1'b0, 1'b0);

    // reset one cycle into BUSY drops the interlock for the next mfhi
    go("mult2", 1'b1, 6'h00, 6'h18, E_MULT, 1'b0, 1'b0);
    step("reset_busy", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, E_BUB, M_ALL, 1'b0, 1'b0, 1'b1);
    go("mfhi",  1'b1, 6'h00, 6'h10, E_MFX,  1'b0, 1'b0);
    go("tail",  1'b0, 6'h00, 6'h00, E_BUB,  1'b0, 1'b0);

    while (sb_q.size() > 0) begin
      @(negedge clk);
      pop_compare();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
